// File: rtl/comp_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH
// iterations per operation, with divide-by-zero short-circuited at start.
module comp_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dvdend,
    input  logic [WIDTH-1:0] Dvsor,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             Rdy,
    output logic             DivZero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [5:0]       count;

    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] s;
    logic             borrow;

    // T keeps the bit shifted out of R so a remainder >= 2^(WIDTH-1) still compares correctly.
    always_comb begin
        t      = {r_q, q_q[WIDTH-1]};
        s      = {1'b0, t} - {2'b00, d_q};
        borrow = s[WIDTH+1];
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            count   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            Rdy     <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Run) begin
                        d_q <= Dvsor;
                        if (Dvsor != '0) begin
                            r_q     <= '0;
                            q_q     <= Dvdend;
                            count   <= '0;
                            Rdy     <= 1'b0;
                            DivZero <= 1'b0;
                            state   <= CALC;
                        end else begin
                            r_q     <= Dvdend;
                            q_q     <= '1;
                            Rdy     <= 1'b1;
                            DivZero <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                CALC: begin
                    if (!borrow) begin
                        r_q <= s[WIDTH-1:0];
                        q_q <= {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_q <= t[WIDTH-1:0];
                        q_q <= {q_q[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 6'd1;
                    if (count == 6'(WIDTH - 1)) begin
                        Rdy   <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Quot = q_q;
    assign Rem  = r_q;

endmodule
